// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a byte FIFO, a serializer
// drains it onto tx, and loads from the window return FIFO/serializer status.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        sel,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   baud, baud_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shift, shift_n;
  logic            tx_n;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            ovf;

  logic            empty, full, busy, pop, push_req, push, ovf_set, ovf_clr;
  logic [7:0]      head;
  logic            unused_bits;

  assign unused_bits = ^{addr[1:0], d_in[31:8]};

  // Bus decode and status
  assign sel      = (addr[31:3] == BASE_ADDR[31:3]);
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign busy     = (state != IDLE);
  assign head     = mem[rd_ptr];
  assign push_req = we & sel & ~addr[2];
  // A full FIFO still accepts a byte when the serializer frees a slot this cycle.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign ovf_clr  = we & sel & addr[2] & d_in[3];

  always_comb begin
    d_out = '0;
    if (sel && addr[2]) begin
      d_out = {16'h0000, 8'(count), 4'h0, ovf, busy, full, empty};
    end
  end

  // FIFO storage holds payload only; occupancy lives in the pointers/count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= d_in[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Serializer next-state; tx is computed from the next state so it leaves a flop
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          baud_n  = '0;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            bit_n   = bit_idx + 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            bit_n   = '0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed and random bus traffic compared against a
// frame-timeline model of the FIFO and serial line.
module tb_mmio_uart_tx;

  localparam int          C    = 4;
  localparam int          D    = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          FRAME = 10 * C;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        sel;
  logic        tx;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  int         rem = 0;
  logic [7:0] cur = 8'h00;
  logic       m_ovf = 1'b0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .d_in(d_in),
    .d_out(d_out), .sel(sel), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {16'h0000, 8'(q.size()), 4'h0, m_ovf, (rem != 0), (q.size() == D), (q.size() == 0)};
  endfunction

  // Line level from position within the current frame: start, 8 data bits LSB first, stop.
  function automatic logic model_tx();
    int idx;
    if (rem == 0) return 1'b1;
    idx = (FRAME - rem) / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur[idx-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    rem   = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic in_win, push_req, full_b, pop, ovf_set;
    in_win   = (a[31:3] == BASE[31:3]);
    push_req = w & in_win & ~a[2];
    full_b   = (q.size() == D);
    pop      = 1'b0;
    if (rem == 0) begin
      if (q.size() > 0) pop = 1'b1;
    end else if (rem == 1) begin
      if (q.size() > 0) pop = 1'b1;
      else rem = 0;
    end else begin
      rem--;
    end
    if (pop) begin
      cur = q.pop_front();
      rem = FRAME;
    end
    ovf_set = push_req & full_b & ~pop;
    if (push_req && !ovf_set) q.push_back(d[7:0]);
    if (ovf_set) m_ovf = 1'b1;
    else if (w && in_win && a[2] && d[3]) m_ovf = 1'b0;
  endtask

  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic in_win;
    @(negedge clk);
    we = w; addr = a; d_in = d;
    #1;
    in_win = (a[31:3] == BASE[31:3]);
    check("sel", {31'b0, sel}, {31'b0, in_win});
    check("d_out", d_out, (in_win && a[2]) ? model_status() : 32'h0);
    @(posedge clk);
    model_edge(w, a, d);
    #1;
    check("tx", {31'b0, tx}, {31'b0, model_tx()});
  endtask

  task automatic idle_step();
    step(1'b0, 32'h0000_0100, 32'h0);
  endtask

  task automatic chk_status(input string tag);
    we = 1'b0; addr = BASE + 32'h4; d_in = 32'h0;
    #1;
    check(tag, d_out, model_status());
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((rem != 0 || q.size() != 0) && n < 3000) begin
      idle_step();
      n++;
    end
    idle_step();
    chk_status(tag);
    check({tag, "_idle"}, d_out, 32'h0000_0001);
  endtask

  initial begin
    logic seqa [10];
    int   cnt_exp [3];
    int   busy_cnt;
    int   n;
    seqa    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    cnt_exp = '{1, 1, 2};

    reset = 1'b1; we = 1'b0; addr = 32'h0; d_in = 32'h0;
    #1;
    check("reset_tx", {31'b0, tx}, 32'h1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Idle after reset
    repeat (50) idle_step();
    chk_status("idle_status");
    check("idle_status_const", d_out, 32'h0000_0001);

    // Single 0xA5 frame
    step(1'b1, BASE, 32'h0000_00A5);
    chk_status("a5_count1");
    check("a5_count1_const", {24'b0, d_out[15:8]}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      idle_step();
      check("a5_seq", {31'b0, tx}, {31'b0, seqa[i/C]});
    end
    idle_step();
    chk_status("a5_done");
    check("a5_busy0", {31'b0, d_out[2]}, 32'h0);

    // Three consecutive writes, contiguous frames
    step(1'b1, BASE, 32'h11);
    chk_status("b3_st0");
    check("b3_cnt0", {24'b0, d_out[15:8]}, cnt_exp[0]);
    step(1'b1, BASE, 32'h22);
    chk_status("b3_st1");
    check("b3_cnt1", {24'b0, d_out[15:8]}, cnt_exp[1]);
    step(1'b1, BASE + 32'h1, 32'h33);
    chk_status("b3_st2");
    check("b3_cnt2", {24'b0, d_out[15:8]}, cnt_exp[2]);
    busy_cnt = 3;
    n = 0;
    while (n < 400) begin
      idle_step();
      chk_status("b3_drain");
      if (d_out[2] !== 1'b1) break;
      busy_cnt++;
      n++;
    end
    // one write-edge sample (the first) was idle, the other two were busy
    check("b3_busy_cycles", busy_cnt - 1, 32'd120);
    check("b3_empty", d_out, 32'h0000_0001);

    // Overflow: ten back-to-back writes into an 8-deep FIFO
    for (int i = 0; i < 10; i++) step(1'b1, BASE, $urandom_range(0, 255));
    chk_status("ovf_status");
    check("ovf_set", {31'b0, d_out[3]}, 32'h1);
    check("ovf_full", {31'b0, d_out[1]}, 32'h1);
    check("ovf_count", {24'b0, d_out[15:8]}, 32'd8);
    step(1'b1, BASE + 32'h4, 32'h8);
    chk_status("ovf_clr_status");
    check("ovf_cleared", {31'b0, d_out[3]}, 32'h0);
    drain("ovf_drain");

    // Reset in the middle of data bit 3
    step(1'b1, BASE, 32'hA5);
    n = 0;
    while (rem != 6 * C - 1 && n < 200) begin
      idle_step();
      n++;
    end
    check("mid_bit3_low", {31'b0, tx}, 32'h0);
    reset = 1'b1;
    #1;
    check("mid_reset_tx", {31'b0, tx}, 32'h1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_status("post_reset_status");
    check("post_reset_const", d_out, 32'h0000_0001);
    repeat (60) idle_step();
    chk_status("post_reset_quiet");

    // Out-of-window stores are ignored
    step(1'b1, BASE + 32'h8, 32'h55);
    check("win_p8_dout", d_out, 32'h0);
    step(1'b1, BASE - 32'h4, 32'h5A);
    step(1'b1, 32'h1000_0040, 32'h77);
    step(1'b1, BASE + 32'hC, 32'h08);
    chk_status("win_fifo_unchanged");
    check("win_const", d_out, 32'h0000_0001);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 4)       a = BASE + 32'($urandom_range(0, 3));
      else if (r < 6)  a = BASE + 32'h4 + 32'($urandom_range(0, 3));
      else if (r < 8)  a = BASE + 32'h8 + 32'($urandom_range(0, 7));
      else             a = $urandom;
      step(($urandom_range(0, 2) != 0), a, $urandom);
      if (i % 25 == 0) chk_status("rand_status");
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
